// File: rtl/t48_p1_seq_pkg.sv
// Shared encodings for the T48 P1 port-operation sequencer.
package t48_pack;

  localparam int unsigned DATA_W = 8;

  typedef enum logic [1:0] {
    OP_IN   = 2'b00,
    OP_OUTL = 2'b01,
    OP_ANL  = 2'b10,
    OP_ORL  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_READ  = 2'b01,
    S_WRITE = 2'b10,
    S_DONE  = 2'b11
  } state_e;

endpackage

// File: rtl/t48_p1_seq.sv
// P1 port-operation sequencer: IN / OUTL / ANL / ORL against the P1 port block.
module t48_p1_seq
  import t48_pack::*;
(
  input  logic              clk_i,
  input  logic              res_i,
  input  logic              en_clk_i,
  input  logic              req_i,
  input  logic [1:0]        op_i,
  input  logic [DATA_W-1:0] imm_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] rdata_o,
  input  logic [DATA_W-1:0] p1_rd_data_i,
  output logic [DATA_W-1:0] p1_wr_data_o,
  output logic              write_p1_o,
  output logic              read_p1_o,
  output logic              read_reg_o
);

  state_e            state_q, state_d;
  op_e               op_q;
  logic [DATA_W-1:0] imm_q;
  logic [DATA_W-1:0] mod_q;
  logic [DATA_W-1:0] rdata_q;

  // State register; advances only on enabled edges.
  always_ff @(posedge clk_i or negedge res_i) begin
    if (!res_i) begin
      state_q <= S_IDLE;
    end else if (en_clk_i) begin
      state_q <= state_d;
    end
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_i) begin
          state_d = (op_e'(op_i) == OP_OUTL) ? S_WRITE : S_READ;
        end
      end
      S_READ:  state_d = (op_q == OP_IN) ? S_DONE : S_WRITE;
      S_WRITE: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Moore strobe and data decode; everything idles at zero outside its state.
  always_comb begin
    busy_o       = (state_q != S_IDLE);
    done_o       = (state_q == S_DONE);
    read_p1_o    = 1'b0;
    read_reg_o   = 1'b0;
    write_p1_o   = 1'b0;
    p1_wr_data_o = '0;
    unique case (state_q)
      S_READ: begin
        read_p1_o  = 1'b1;
        read_reg_o = (op_q != OP_IN);
      end
      S_WRITE: begin
        write_p1_o   = 1'b1;
        p1_wr_data_o = (op_q == OP_OUTL) ? imm_q : mod_q;
      end
      default: ;
    endcase
  end

  // Operand latch, read-modify-write capture and result register.
  always_ff @(posedge clk_i or negedge res_i) begin
    if (!res_i) begin
      op_q    <= OP_IN;
      imm_q   <= '0;
      mod_q   <= '0;
      rdata_q <= '0;
    end else if (en_clk_i) begin
      unique case (state_q)
        S_IDLE: begin
          if (req_i) begin
            op_q  <= op_e'(op_i);
            imm_q <= imm_i;
          end
        end
        S_READ: begin
          unique case (op_q)
            OP_IN:   rdata_q <= p1_rd_data_i;
            OP_ANL:  mod_q   <= p1_rd_data_i & imm_q;
            OP_ORL:  mod_q   <= p1_rd_data_i | imm_q;
            default: ;
          endcase
        end
        S_WRITE: rdata_q <= p1_wr_data_o;
        default: ;
      endcase
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: tb/tb_t48_p1_seq.sv
// Bench for t48_p1_seq: directed cases plus randomized traffic against a
// phase-list model of each operation.
module tb_t48_p1_seq;
  import t48_pack::*;

  logic       clk = 1'b0;
  logic       res_i = 1'b0;
  logic       en = 1'b1;
  logic       req = 1'b0;
  logic [1:0] op = 2'b00;
  logic [7:0] imm = 8'h00;
  logic [7:0] pins = 8'h00;
  logic       busy_o, done_o, write_p1_o, read_p1_o, read_reg_o;
  logic [7:0] rdata_o, p1_wr_data_o, p1_rd_data;

  int total = 0;
  int bad   = 0;
  int en_mode = 0;

  // P1 port block stand-in: latch written by write strobes, pins from the bench.
  logic [7:0] port_latch = 8'h00;
  logic [7:0] last_wd = 8'h00;
  int         wr_cnt = 0;

  assign p1_rd_data = read_reg_o ? port_latch : pins;

  t48_p1_seq dut (
    .clk_i       (clk),
    .res_i       (res_i),
    .en_clk_i    (en),
    .req_i       (req),
    .op_i        (op),
    .imm_i       (imm),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .rdata_o     (rdata_o),
    .p1_rd_data_i(p1_rd_data),
    .p1_wr_data_o(p1_wr_data_o),
    .write_p1_o  (write_p1_o),
    .read_p1_o   (read_p1_o),
    .read_reg_o  (read_reg_o)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) begin
    if (res_i && en && write_p1_o) begin
      port_latch <= p1_wr_data_o;
      last_wd    <= p1_wr_data_o;
      wr_cnt     <= wr_cnt + 1;
    end
  end

  // Clock-enable pattern: always on, 1-of-3, or random ~70%.
  initial begin
    int cnt = 0;
    forever begin
      @(negedge clk);
      #1;
      case (en_mode)
        0:       en = 1'b1;
        1:       en = ((cnt % 3) == 0);
        default: en = ($urandom_range(0, 9) < 7);
      endcase
      cnt++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: each accepted operation becomes a list of per-enabled-cycle output
  // phases; idle means the list is empty.
  typedef struct {
    logic       done;
    logic       rd;
    logic       rr;
    logic       wr;
    logic [7:0] wd;
    logic [7:0] rdat;
  } ph_t;

  ph_t        q[$];
  logic [7:0] m_rdata = 8'h00;
  logic [7:0] m_latch = 8'h00;

  function automatic ph_t mk(logic d, logic rd, logic rr, logic wr, logic [7:0] wd, logic [7:0] rv);
    ph_t p;
    p.done = d; p.rd = rd; p.rr = rr; p.wr = wr; p.wd = wd; p.rdat = rv;
    return p;
  endfunction

  always @(posedge clk or negedge res_i) begin
    if (!res_i) begin
      q.delete();
      m_rdata = 8'h00;
    end else if (en) begin
      if (q.size() > 0) begin
        ph_t p;
        p = q.pop_front();
        m_rdata = p.rdat;
        if (p.wr) m_latch = p.wd;
      end else if (req) begin
        logic [7:0] r;
        case (op)
          2'b00: begin
            q.push_back(mk(0, 1, 0, 0, 8'h00, m_rdata));
            q.push_back(mk(1, 0, 0, 0, 8'h00, pins));
          end
          2'b01: begin
            q.push_back(mk(0, 0, 0, 1, imm, m_rdata));
            q.push_back(mk(1, 0, 0, 0, 8'h00, imm));
          end
          default: begin
            r = (op == 2'b10) ? (m_latch & imm) : (m_latch | imm);
            q.push_back(mk(0, 1, 1, 0, 8'h00, m_rdata));
            q.push_back(mk(0, 0, 0, 1, r, m_rdata));
            q.push_back(mk(1, 0, 0, 0, 8'h00, r));
          end
        endcase
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    ph_t e;
    logic eb;
    eb = (q.size() > 0);
    e  = eb ? q[0] : mk(0, 0, 0, 0, 8'h00, m_rdata);
    chk("cyc_busy",  {31'd0, busy_o},     {31'd0, eb});
    chk("cyc_done",  {31'd0, done_o},     {31'd0, e.done});
    chk("cyc_rd",    {31'd0, read_p1_o},  {31'd0, e.rd});
    chk("cyc_rr",    {31'd0, read_reg_o}, {31'd0, e.rr});
    chk("cyc_wr",    {31'd0, write_p1_o}, {31'd0, e.wr});
    chk("cyc_wdata", {24'd0, p1_wr_data_o}, {24'd0, e.wd});
    chk("cyc_rdata", {24'd0, rdata_o},    {24'd0, e.rdat});
    chk("cyc_excl",  {31'd0, write_p1_o & read_p1_o}, 32'd0);
  end

  // Issue one operation from idle; returns enabled-edge latency, result,
  // write strobes seen and the read_reg_o value seen during READ.
  task automatic do_op(input logic [1:0] o, input logic [7:0] d,
                       output int lat, output logic [7:0] res,
                       output int wrs, output logic rr_seen);
    int   wr0;
    logic acc, got;
    wr0 = wr_cnt; acc = 0; got = 0; lat = 1; res = 8'h00; rr_seen = 1'bx;
    op = o; imm = d; req = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      if (en) begin acc = 1; break; end
    end
    chk("accept_in_time", {31'd0, acc}, 32'd1);
    @(negedge clk);
    req = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (read_p1_o) rr_seen = read_reg_o;
      if (done_o) begin got = 1; res = rdata_o; break; end
      @(posedge clk);
      if (en) lat++;
      @(negedge clk);
    end
    chk("done_in_time", {31'd0, got}, 32'd1);
    for (int i = 0; i < 60; i++) begin
      if (!busy_o) break;
      @(negedge clk);
    end
    #1;
    wrs = wr_cnt - wr0;
  endtask

  initial begin
    int         lat, wrs, dcnt, w0;
    logic [7:0] res;
    logic       rr;

    repeat (3) @(negedge clk);
    chk("rst_busy",  {31'd0, busy_o}, 32'd0);
    chk("rst_rdata", {24'd0, rdata_o}, 32'd0);
    #1 res_i = 1'b1;

    // OUTL 5A
    do_op(2'b01, 8'h5A, lat, res, wrs, rr);
    chk("outl_lat", lat, 2);
    chk("outl_res", {24'd0, res}, 32'h5A);
    chk("outl_wrs", wrs, 1);
    chk("outl_wd",  {24'd0, last_wd}, 32'h5A);

    // ANL F0 & 3C
    do_op(2'b01, 8'hF0, lat, res, wrs, rr);
    do_op(2'b10, 8'h3C, lat, res, wrs, rr);
    chk("anl_rr",  {31'd0, rr}, 32'd1);
    chk("anl_lat", lat, 3);
    chk("anl_res", {24'd0, res}, 32'h30);
    chk("anl_wd",  {24'd0, last_wd}, 32'h30);

    // ORL 0F | A0, then IN from pins
    do_op(2'b01, 8'h0F, lat, res, wrs, rr);
    do_op(2'b11, 8'hA0, lat, res, wrs, rr);
    chk("orl_wd",  {24'd0, last_wd}, 32'hAF);
    chk("orl_res", {24'd0, res}, 32'hAF);
    pins = 8'h81;
    do_op(2'b00, 8'h00, lat, res, wrs, rr);
    chk("in_rr",  {31'd0, rr}, 32'd0);
    chk("in_lat", lat, 2);
    chk("in_res", {24'd0, res}, 32'h81);

    // ANL with clock enable at 1-of-3
    do_op(2'b01, 8'hF0, lat, res, wrs, rr);
    en_mode = 1;
    do_op(2'b10, 8'h3C, lat, res, wrs, rr);
    chk("stall_lat", lat, 3);
    chk("stall_res", {24'd0, res}, 32'h30);
    chk("stall_wrs", wrs, 1);
    en_mode = 0;
    @(negedge clk); #1;

    // req held high across back-to-back OUTLs: one accept every 3 edges
    w0 = wr_cnt; dcnt = 0;
    op = 2'b01; imm = 8'h77; req = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (done_o) dcnt++;
    end
    req = 1'b0;
    #1;
    chk("hold_dones", dcnt, 3);
    chk("hold_wrs", wr_cnt - w0, 3);

    // Reset during READ of ORL aborts with no write
    w0 = wr_cnt;
    op = 2'b11; imm = 8'h08; req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    chk("abort_in_read", {31'd0, read_p1_o}, 32'd1);
    #1 res_i = 1'b0;
    #1;
    chk("abort_outs", {21'd0, busy_o, done_o, read_p1_o, read_reg_o, write_p1_o, rdata_o | p1_wr_data_o}, 32'd0);
    @(negedge clk); #1 res_i = 1'b1;
    repeat (3) @(negedge clk);
    chk("abort_no_wr", wr_cnt - w0, 0);
    chk("abort_latch", {24'd0, port_latch}, 32'h77);
    #1;
    do_op(2'b01, 8'h11, lat, res, wrs, rr);
    chk("post_rst_lat", lat, 2);
    chk("post_rst_res", {24'd0, res}, 32'h11);
    chk("model_latch", {24'd0, m_latch}, 32'h11);

    // Randomized traffic, random enable, occasional reset pulses
    en_mode = 2;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk); #2;
      if ($urandom_range(0, 199) == 0) begin
        res_i = 1'b0; #2 res_i = 1'b1;
      end
      req = ($urandom_range(0, 2) == 0);
      op  = 2'($urandom_range(0, 3));
      imm = 8'($urandom);
      if ($urandom_range(0, 9) == 0) imm = ($urandom_range(0, 1) == 0) ? 8'hFF : 8'h00;
      if (!req && q.size() == 0) pins = 8'($urandom);
    end
    req = 1'b0;
    repeat (30) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/t48_p1_seq.md
T48_P1_SEQ -- requirements
Module: t48_p1_seq

Interface
REQ-001 clk_i  in  1  system clock; all state changes occur on its rising edge.
REQ-002 res_i  in  1  reset, asynchronous, active-low.
REQ-003 en_clk_i  in  1  clock enable; the FSM and all registers advance only when this is 1.
REQ-004 req_i  in  1  port-operation request; it is sampled only in IDLE.
REQ-005 op_i  in  2  operation select: 00 IN, 01 OUTL, 10 ANL, 11 ORL.
REQ-006 imm_i  in  8  immediate or write data, latched on acceptance.
REQ-007 busy_o  out  1  high in every state except IDLE.
REQ-008 done_o  out  1  high only while the FSM is in state DONE.
REQ-009 rdata_o  out  8  result register: port value read (IN) or value written (OUTL/ANL/ORL).
REQ-010 p1_rd_data_i  in  8  read data returned by the P1 port block, combinational from its read strobes.
REQ-011 p1_wr_data_o  out  8  write data to the P1 port block.
REQ-012 write_p1_o  out  1  write strobe to the P1 port block.
REQ-013 read_p1_o  out  1  read strobe to the P1 port block.
REQ-014 read_reg_o  out  1  selects a latch read (1) or a pin read (0).

Function
REQ-015 The FSM states SHALL be IDLE, READ, WRITE and DONE; every transition SHALL require en_clk_i=1, otherwise the state holds.
REQ-016 In IDLE with req_i=1, op_i and imm_i SHALL be latched into op_q and imm_q.
- Next state: READ for IN, ANL or ORL; WRITE for OUTL.
REQ-017 In IDLE, req_i=0 SHALL keep the FSM in IDLE.
- req_i is ignored in every other state; there is no queueing.
REQ-018 In READ, read_p1_o SHALL be 1.
- read_reg_o: 0 for IN (pins); 1 for ANL and ORL (latch, read-modify-write).
REQ-019 On the enabled READ edge, the capture and next state SHALL be:
- IN: rdata_o <= p1_rd_data_i, next DONE.
- ANL: mod_q <= p1_rd_data_i AND imm_q, next WRITE.
- ORL: mod_q <= p1_rd_data_i OR imm_q, next WRITE.
REQ-020 In WRITE, write_p1_o SHALL be 1.
- p1_wr_data_o: imm_q for OUTL, mod_q for ANL and ORL.
- On the enabled edge: rdata_o <= p1_wr_data_o, next DONE.
REQ-021 In DONE, the FSM SHALL move to IDLE on the next enabled edge.
- done_o is therefore high for exactly one enabled cycle, plus any stall cycles where en_clk_i=0.
REQ-022 All port strobes SHALL be Moore outputs decoded from the state only, and at most one of write_p1_o or read_p1_o SHALL be high at any time.
REQ-023 Outside its strobe states, p1_wr_data_o SHALL be 8'h00 and write_p1_o, read_p1_o and read_reg_o SHALL be 0.
REQ-024 Latency in enabled cycles from acceptance to done_o high SHALL be: IN 2, OUTL 2, ANL/ORL 3.
REQ-025 A new request SHALL be accepted no sooner than the enabled edge after DONE, so back-to-back operations have 1 IDLE cycle between them.
REQ-026 All arithmetic SHALL be 8-bit bitwise with no carry; 8'hFF and 8'h00 operands SHALL pass through unchanged.

Reset
REQ-027 When res_i=0, the block SHALL asynchronously force:
- state IDLE;
- op_q=00, imm_q=8'h00, mod_q=8'h00, rdata_o=8'h00;
- busy_o=0, done_o=0, all strobes 0.
REQ-028 A reset during READ or WRITE SHALL abort the operation with no further write strobe and no done_o pulse.
REQ-029 After release, the first enabled edge with req_i=1 SHALL be accepted normally.

Structure
REQ-030 A shared package t48_pack SHALL hold:
- op encodings OP_IN, OP_OUTL, OP_ANL, OP_ORL;
- state encodings for IDLE, READ, WRITE, DONE;
- constants for the data width (8).
REQ-031 The block SHALL be a single FSM module with no sub-module.
- Integration instantiates t48_p1_seq beside t48_p1, connecting the strobes and data 1:1.

Verification
REQ-032 Bench 1: reset, then OUTL imm=8'h5A with en_clk_i always 1.
- Required: write_p1_o high for 1 cycle with p1_wr_data_o=8'h5A.
- Required: done_o high 2 cycles after acceptance; rdata_o=8'h5A.
REQ-033 Bench 2: port latch=8'hF0, ANL imm=8'h3C.
- Required: read_reg_o=1 during READ.
- Required: write data 8'h30 and rdata_o=8'h30, latency 3.
REQ-034 Bench 3: latch=8'h0F, ORL imm=8'hA0.
- Required: write data 8'hAF; then IN with pins=8'h81 gives read_reg_o=0 and rdata_o=8'h81.
REQ-035 Bench 4: en_clk_i toggling 1-of-3 during ANL.
- Required: the state holds on disabled cycles and the result is identical to Bench 2.
- Required: exactly one write strobe is sampled while en_clk_i=1.
REQ-036 Bench 5: req_i held high through a whole OUTL.
- Required: the second acceptance occurs only after DONE->IDLE, and busy_o never drops mid-operation.
REQ-037 Bench 6: res_i driven low while in READ of ORL.
- Required: all outputs 0 immediately, no write_p1_o, no done_o.
- Required: the next OUTL 8'h11 completes normally.
